// File: rtl/insmem_loader.sv
// insmem_loader: streams a program into instruction memory, holding the CPU in halt until loaded.
// Optional trailing-checksum verification is built when INSMEM_LOADER_CHECKSUM_EN is defined.
module insmem_loader #(
  parameter int DEPTH = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_halt,
  output logic        done,
  output logic        err,
  output logic [8:0]  byte_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef INSMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [9:0] LP_DEPTH = 10'(DEPTH);

  state_t      r_state;
  logic [8:0]  r_len;
  logic [8:0]  r_count;
  logic        r_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_halt;
  logic        r_done;
  logic        r_err;
`ifdef INSMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic w_len_bad;
  logic w_accept;
  logic w_last;

  assign w_len_bad = (len == 9'd0) ||
                     ({1'b0, len} > LP_DEPTH);
  assign w_accept  = in_valid && r_ready;
  assign w_last    = ((r_count + 9'd1) == r_len);

  assign in_ready   = r_ready;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_halt   = r_halt;
  assign done       = r_done;
  assign err        = r_err;
  assign byte_count = r_count;

  // Load FSM with all outputs registered; write pulse trails each accepted byte by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= 9'd0;
      r_count <= 9'd0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 8'd0;
      r_halt  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef INSMEM_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_done <= 1'b0;
            r_halt <= 1'b1;
            if (w_len_bad) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_LOAD;
              r_len   <= len;
              r_count <= 9'd0;
              r_err   <= 1'b0;
              r_ready <= 1'b1;
`ifdef INSMEM_LOADER_CHECKSUM_EN
              r_sum   <= 8'd0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_addr  <= {23'd0, r_count};
            r_wdata <= in_data;
            r_count <= r_count + 9'd1;
`ifdef INSMEM_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + in_data;
            if (w_last) begin
              r_state <= S_CHECK;
            end
`else
            if (w_last) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
            end
`endif
          end
        end
`ifdef INSMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (in_data == r_sum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_halt  <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

endmodule
